// File: rtl/reg_pipe.sv
// Elastic DEPTH-stage register pipeline with valid/ready handshake, bubble collapsing,
// synchronous flush and occupancy count. Define REG_PIPE_STALL_CNT_EN to add stall_cnt.
module reg_pipe #(
  parameter int unsigned SIZEDATA = 32,
  parameter int unsigned DEPTH    = 2,
  parameter int unsigned CNTW     = $clog2(DEPTH + 1)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                clear,
  input  logic [SIZEDATA-1:0] in_data,
  input  logic                in_valid,
  output logic                in_ready,
  output logic [SIZEDATA-1:0] out_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [CNTW-1:0]     count
`ifdef REG_PIPE_STALL_CNT_EN
  ,
  output logic [31:0]         stall_cnt
`endif
);

  logic [SIZEDATA-1:0] data_q [DEPTH];
  logic [SIZEDATA-1:0] data_d [DEPTH];
  logic [DEPTH-1:0]    valid_q, valid_d;
  logic [DEPTH:0]      rdy;
  logic [CNTW-1:0]     count_q, count_d;
  logic                in_xfer, out_xfer;

  // A stage can load when it is empty or the stage after it is moving.
  always_comb begin : ready_chain
    logic r;
    rdy = '0;
    r = out_ready;
    rdy[DEPTH] = r;
    for (int k = int'(DEPTH) - 1; k >= 0; k--) begin
      r = !valid_q[k] || r;
      rdy[k] = r;
    end
  end

  assign in_ready  = rdy[0] && !clear;
  assign out_valid = valid_q[DEPTH-1];
  assign out_data  = data_q[DEPTH-1];
  assign in_xfer   = in_valid && in_ready;
  assign out_xfer  = out_valid && out_ready;
  assign count     = count_q;

  always_comb begin
    valid_d = valid_q;
    for (int k = 0; k < int'(DEPTH); k++) begin
      data_d[k] = data_q[k];
    end
    if (clear) begin
      valid_d = '0;
      for (int k = 0; k < int'(DEPTH); k++) begin
        data_d[k] = '0;
      end
    end else begin
      if (rdy[0]) begin
        valid_d[0] = in_valid;
        data_d[0]  = in_data;
      end
      for (int k = 1; k < int'(DEPTH); k++) begin
        if (rdy[k]) begin
          valid_d[k] = valid_q[k-1];
          data_d[k]  = data_q[k-1];
        end
      end
    end
  end

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (in_xfer && !out_xfer) begin
      count_d = count_q + CNTW'(1);
    end else if (!in_xfer && out_xfer) begin
      count_d = count_q - CNTW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= '0;
      count_q <= '0;
      for (int k = 0; k < int'(DEPTH); k++) begin
        data_q[k] <= '0;
      end
    end else begin
      valid_q <= valid_d;
      count_q <= count_d;
      for (int k = 0; k < int'(DEPTH); k++) begin
        data_q[k] <= data_d[k];
      end
    end
  end

`ifdef REG_PIPE_STALL_CNT_EN
  logic [31:0] stall_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_q <= '0;
    end else if (clear) begin
      stall_q <= '0;
    end else if (out_valid && !out_ready && stall_q != '1) begin
      stall_q <= stall_q + 32'd1;
    end
  end

  assign stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_reg_pipe.sv
// Scoreboard bench for reg_pipe (DEPTH=3, SIZEDATA=8): the driver queues accepted words,
// a negedge monitor pops and compares on every output transfer.
module tb_reg_pipe;
  localparam int unsigned W  = 8;
  localparam int unsigned D  = 3;
  localparam int unsigned CW = $clog2(D + 1);

  logic          clk = 1'b0;
  logic          reset, clear, in_valid, in_ready, out_valid, out_ready;
  logic [W-1:0]  in_data, out_data;
  logic [CW-1:0] count;
`ifdef REG_PIPE_STALL_CNT_EN
  logic [31:0]   stall_cnt;
`endif

  int checks = 0;
  int errors = 0;
  int n_out  = 0;
  logic [W-1:0] exp_q[$];

  always #5 clk = ~clk;

  reg_pipe #(
    .SIZEDATA(W),
    .DEPTH   (D)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .clear    (clear),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .count    (count)
`ifdef REG_PIPE_STALL_CNT_EN
    ,
    .stall_cnt(stall_cnt)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input bit v, input logic [W-1:0] d, input bit ordy, input bit clr);
    in_valid  = v;
    in_data   = d;
    out_ready = ordy;
    clear     = clr;
    #1;
  endtask

  // Records accepted words at mid-cycle, then advances to just after the next rising edge.
  task automatic tick(output bit acc);
    @(negedge clk);
    acc = in_valid && in_ready;
    if (acc) exp_q.push_back(in_data);
    if (clear || reset) exp_q.delete();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (!reset && !clear && out_valid && out_ready) begin
      n_out++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_out: got %0h expected no output", out_data);
      end else begin
        chk("out_data", 32'(out_data), 32'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    #100000;
    errors++;
    $display("FAIL watchdog: got timeout expected finish");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "timeout");
  end

  initial begin
    bit acc;
    int idx;
    int nacc;
    int n0;
    logic [W-1:0] t1d [6];
    logic         t1v [6];
    logic [CW-1:0] t1c [6];
    t1d = '{8'h11, 8'h22, 8'h33, 8'h00, 8'h00, 8'h00};
    t1v = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    t1c = '{2'd1, 2'd2, 2'd3, 2'd2, 2'd1, 2'd0};

    reset = 1'b1; clear = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    #12;
    reset = 1'b0;
    @(posedge clk); #1;
    chk("rst_count", 32'(count), 0);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_data", 32'(out_data), 0);
    chk("rst_in_ready", 32'(in_ready), 1);

    // Back-to-back stream, unstalled: latency 3, count peaks at 3.
    for (int i = 0; i < 6; i++) begin
      drive(i < 3, t1d[i], 1'b1, 1'b0);
      tick(acc);
      chk("t1_out_valid", 32'(out_valid), 32'(t1v[i]));
      chk("t1_count", 32'(count), 32'(t1c[i]));
    end

    // Stalled output: only three words absorbed, then release.
    idx = 0;
    for (int c = 0; c < 4; c++) begin
      drive(1'b1, W'(8'hA0 + idx), 1'b0, 1'b0);
      chk("t2_in_ready", 32'(in_ready), 32'(c < 3));
      tick(acc);
      if (acc) idx++;
    end
    chk("t2_accepted", 32'(idx), 3);
    chk("t2_count", 32'(count), 3);
    for (int c = 0; c < 20 && idx < 5; c++) begin
      drive(1'b1, W'(8'hA0 + idx), 1'b1, 1'b0);
      chk("t2_in_ready_full_ordy", 32'(in_ready), 1);
      tick(acc);
      if (acc) idx++;
    end
    chk("t2_all_in", 32'(idx), 5);
    drive(1'b0, '0, 1'b1, 1'b0);
    repeat (4) tick(acc);
    chk("t2_drained", 32'(count), 0);

    // Full pipe streaming at full rate.
    for (int c = 0; c < 3; c++) begin
      drive(1'b1, W'(8'hB0 + c), 1'b0, 1'b0);
      tick(acc);
    end
    chk("t3_full", 32'(count), 3);
    n0 = n_out;
    nacc = 0;
    for (int c = 0; c < 10; c++) begin
      drive(1'b1, W'(8'hC0 + c), 1'b1, 1'b0);
      chk("t3_in_ready", 32'(in_ready), 1);
      tick(acc);
      if (acc) nacc++;
      chk("t3_count", 32'(count), 3);
    end
    chk("t3_words_in", 32'(nacc), 10);
    chk("t3_words_out", 32'(n_out - n0), 10);
    drive(1'b0, '0, 1'b1, 1'b0);
    repeat (3) tick(acc);
    chk("t3_drained", 32'(count), 0);

    // Clear on a full pipe drops contents and the same-cycle input.
    for (int c = 0; c < 3; c++) begin
      drive(1'b1, W'(8'h55 + c), 1'b0, 1'b0);
      tick(acc);
    end
    chk("t4_full", 32'(count), 3);
    drive(1'b1, 8'h99, 1'b1, 1'b1);
    chk("t4_in_ready_clear", 32'(in_ready), 0);
    chk("t4_out_valid_clear", 32'(out_valid), 1);
    tick(acc);
    drive(1'b0, '0, 1'b1, 1'b0);
    chk("t4_count", 32'(count), 0);
    chk("t4_out_valid", 32'(out_valid), 0);
    chk("t4_out_data", 32'(out_data), 0);
    repeat (4) tick(acc);

    // Asynchronous reset in the middle of a burst.
    for (int c = 0; c < 3; c++) begin
      drive(1'b1, W'(8'hE0 + c), 1'b1, 1'b0);
      tick(acc);
    end
    drive(1'b0, '0, 1'b1, 1'b0);
    tick(acc);
    chk("t5_count_pre", 32'(count), 2);
    chk("t5_out_valid_pre", 32'(out_valid), 1);
    chk("t5_out_data_pre", 32'(out_data), 32'hE1);
    drive(1'b0, '0, 1'b0, 1'b0);
    #1 reset = 1'b1;
    #1;
    chk("t5_rst_out_valid", 32'(out_valid), 0);
    chk("t5_rst_count", 32'(count), 0);
    chk("t5_rst_out_data", 32'(out_data), 0);
    exp_q.delete();
    #2 reset = 1'b0;
    @(posedge clk); #1;
    for (int c = 0; c < 3; c++) begin
      drive(c == 0, 8'h7E, 1'b1, 1'b0);
      tick(acc);
      chk("t5_latency", 32'(out_valid), 32'(c == 2));
    end
    chk("t5_out_data", 32'(out_data), 32'h7E);
    drive(1'b0, '0, 1'b1, 1'b0);
    repeat (2) tick(acc);
    chk("t5_drained", 32'(count), 0);

`ifdef REG_PIPE_STALL_CNT_EN
    drive(1'b0, '0, 1'b0, 1'b1);
    tick(acc);
    chk("stall_cleared_start", stall_cnt, 0);
    drive(1'b1, 8'hF0, 1'b0, 1'b0);
    tick(acc);
    drive(1'b0, '0, 1'b0, 1'b0);
    repeat (2) tick(acc);
    chk("stall_out_valid", 32'(out_valid), 1);
    repeat (5) tick(acc);
    chk("stall_cnt_5", stall_cnt, 5);
    drive(1'b0, '0, 1'b0, 1'b1);
    tick(acc);
    chk("stall_cnt_clear", stall_cnt, 0);
    drive(1'b0, '0, 1'b1, 1'b0);
    tick(acc);
`endif

    chk("scoreboard_empty", 32'(exp_q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
